// File: rtl/adc_range_guard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adc_range_guard_pkg
// Purpose : Shared types for the ADC range guard -- the protection state
//           encoding used by the guard FSM and visible to any block that
//           needs to decode it.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package adc_range_guard_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_NORMAL  = 2'd0,
    ST_PENDING = 2'd1,
    ST_TRIPPED = 2'd2
  } guard_state_e;

endpackage : adc_range_guard_pkg
`default_nettype wire

// File: rtl/window_comparator.sv
`default_nettype none
// ============================================================================
// Module  : window_comparator
// Purpose : Signed strict window compare of one sample against an upper and
//           a lower threshold.
// Ports   : data_i      - signed sample
//           thr_high_i  - signed upper threshold
//           thr_low_i   - signed lower threshold
//           above_o     - data_i >  thr_high_i
//           below_o     - data_i <  thr_low_i
// Revision: 1.0 - initial release
// ============================================================================
module window_comparator #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] data_i,
  input  logic signed [WIDTH-1:0] thr_high_i,
  input  logic signed [WIDTH-1:0] thr_low_i,
  output logic                    above_o,
  output logic                    below_o
);

  // With thr_low > thr_high every value is either above the upper or below
  // the lower limit, so an inverted window naturally flags every sample.
  assign above_o = (data_i > thr_high_i);
  assign below_o = (data_i < thr_low_i);

endmodule : window_comparator
`default_nettype wire

// File: rtl/adc_range_guard.sv
`default_nettype none
// ============================================================================
// Module  : adc_range_guard
// Purpose : Over/under-range protection on a calibrated ADC sample stream.
//           Consecutive out-of-range transfers are debounced; once tripped
//           the stream is zeroed until trip_clear or trip_enable drops.
// Ports   : clock, reset (async, active-low)
//           pipeline_flush  - drop in-flight output and pending debounce
//           thr_high/thr_low- signed trip window
//           debounce_len    - out-of-range transfers needed to trip
//           trip_enable     - low forces NORMAL and pass-through
//           trip_clear      - leave TRIPPED
//           data_in_*       - stream slave (valid/ready/data)
//           data_out_*      - stream master (valid/ready/data), latency 1
//           fault           - high while TRIPPED
//           fault_high      - direction of the tripping sample (1 = upper)
// Revision: 1.0 - initial release
// ============================================================================
module adc_range_guard
  import adc_range_guard_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 16,
  parameter int COUNTER_WIDTH   = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              pipeline_flush,
  input  logic signed [DATA_PATH_WIDTH-1:0] thr_high,
  input  logic signed [DATA_PATH_WIDTH-1:0] thr_low,
  input  logic        [COUNTER_WIDTH-1:0]   debounce_len,
  input  logic                              trip_enable,
  input  logic                              trip_clear,
  input  logic                              data_in_valid,
  output logic                              data_in_ready,
  input  logic signed [DATA_PATH_WIDTH-1:0] data_in_data,
  output logic                              data_out_valid,
  input  logic                              data_out_ready,
  output logic signed [DATA_PATH_WIDTH-1:0] data_out_data,
  output logic                              fault,
  output logic                              fault_high
);

  guard_state_e                      state_q, state_d;
  logic [COUNTER_WIDTH-1:0]          count_q, count_d;
  logic                              fault_high_q, fault_high_d;
  logic                              dout_valid_q, dout_valid_d;
  logic signed [DATA_PATH_WIDTH-1:0] dout_data_q, dout_data_d;

  logic                              xfer_w;
  logic                              above_w;
  logic                              below_w;
  logic                              oor_w;
  logic                              zero_out_w;
  logic [COUNTER_WIDTH:0]            count_inc_w;

  window_comparator #(
    .WIDTH (DATA_PATH_WIDTH)
  ) u_window_comparator (
    .data_i     (data_in_data),
    .thr_high_i (thr_high),
    .thr_low_i  (thr_low),
    .above_o    (above_w),
    .below_o    (below_w)
  );

  // No internal buffering: the upstream may only move when downstream can.
  assign data_in_ready = data_out_ready;
  assign xfer_w        = data_in_valid & data_out_ready;
  assign oor_w         = above_w | below_w;

  // Extra bit so the increment cannot wrap before the compare.
  assign count_inc_w   = {1'b0, count_q} + {{COUNTER_WIDTH{1'b0}}, 1'b1};

  // Samples arriving while already TRIPPED are blanked; the sample that
  // causes the trip is still in PENDING/NORMAL and therefore passes.
  assign zero_out_w    = (state_q == ST_TRIPPED) && trip_enable;

  // --------------------------------------------------------------------------
  // Protection FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    fault_high_d = fault_high_q;

    if (!trip_enable) begin
      state_d = ST_NORMAL;
      count_d = '0;
    end else if ((state_q == ST_TRIPPED) && trip_clear) begin
      // Clear wins over any sample transferred in the same cycle.
      state_d = ST_NORMAL;
      count_d = '0;
    end else if (pipeline_flush) begin
      // Flush drops pending debounce but never releases a trip.
      if (state_q == ST_PENDING) begin
        state_d = ST_NORMAL;
        count_d = '0;
      end
    end else if (xfer_w) begin
      unique case (state_q)
        ST_NORMAL: begin
          if (oor_w) begin
            if (debounce_len <= COUNTER_WIDTH'(1)) begin
              state_d      = ST_TRIPPED;
              count_d      = '0;
              fault_high_d = above_w;
            end else begin
              state_d = ST_PENDING;
              count_d = COUNTER_WIDTH'(1);
            end
          end
        end
        ST_PENDING: begin
          if (oor_w) begin
            // >= also covers debounce_len lowered below the current count.
            if (count_inc_w >= {1'b0, debounce_len}) begin
              state_d      = ST_TRIPPED;
              count_d      = '0;
              fault_high_d = above_w;
            end else begin
              count_d = count_inc_w[COUNTER_WIDTH-1:0];
            end
          end else begin
            state_d = ST_NORMAL;
            count_d = '0;
          end
        end
        ST_TRIPPED: begin
          state_d = ST_TRIPPED;
        end
        default: begin
          state_d = ST_NORMAL;
          count_d = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output stage: one register, latency 1
  // --------------------------------------------------------------------------
  always_comb begin
    dout_valid_d = xfer_w & ~pipeline_flush;
    dout_data_d  = dout_data_q;
    if (xfer_w) begin
      dout_data_d = zero_out_w ? '0 : data_in_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_NORMAL;
      count_q      <= '0;
      fault_high_q <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      fault_high_q <= fault_high_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
    end
  end

  assign data_out_valid = dout_valid_q;
  assign data_out_data  = dout_data_q;
  assign fault          = (state_q == ST_TRIPPED);
  assign fault_high     = fault_high_q;

endmodule : adc_range_guard
`default_nettype wire

// File: tb/tb_adc_range_guard.sv
`default_nettype none
// ============================================================================
// Module  : tb_adc_range_guard
// Purpose : Self-checking bench for adc_range_guard: directed vector table,
//           hand-written stall/reset/threshold sequences, and a randomized
//           run against a run-length reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adc_range_guard;

  logic               clock;
  logic               reset;
  logic               pipeline_flush;
  logic signed [15:0] thr_high;
  logic signed [15:0] thr_low;
  logic        [7:0]  debounce_len;
  logic               trip_enable;
  logic               trip_clear;
  logic               data_in_valid;
  logic               data_in_ready;
  logic signed [15:0] data_in_data;
  logic               data_out_valid;
  logic               data_out_ready;
  logic signed [15:0] data_out_data;
  logic               fault;
  logic               fault_high;

  int n_checks = 0;
  int n_err    = 0;

  adc_range_guard #(
    .DATA_PATH_WIDTH (16),
    .COUNTER_WIDTH   (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pipeline_flush (pipeline_flush),
    .thr_high       (thr_high),
    .thr_low        (thr_low),
    .debounce_len   (debounce_len),
    .trip_enable    (trip_enable),
    .trip_clear     (trip_clear),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_in_data   (data_in_data),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_data  (data_out_data),
    .fault          (fault),
    .fault_high     (fault_high)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit r, input int d, input bit fl,
                       input bit clr, input bit en);
    data_in_valid  = v;
    data_out_ready = r;
    data_in_data   = 16'(d);
    pipeline_flush = fl;
    trip_clear     = clr;
    trip_enable    = en;
  endtask

  // One clock: inputs already driven; returns at posedge + 1.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input bit v, input int d,
                            input bit f, input bit fh);
    chk({tag, ".valid"}, data_out_valid, v);
    chk({tag, ".data"},  data_out_data,  d);
    chk({tag, ".fault"}, fault,          f);
    chk({tag, ".fh"},    fault_high,     fh);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: tracks the length of the current run of consecutive
  // out-of-range transfers and a tripped flag.
  // --------------------------------------------------------------------------
  bit m_tripped;
  int m_run;
  bit m_fh;
  bit m_valid;
  int m_data;

  task automatic model_reset();
    m_tripped = 0; m_run = 0; m_fh = 0; m_valid = 0; m_data = 0;
  endtask

  task automatic model_edge();
    bit xfer;
    bit hi;
    bit lo;
    int d;
    xfer = data_in_valid && data_out_ready;
    d    = int'(data_in_data);
    hi   = d > int'(thr_high);
    lo   = d < int'(thr_low);
    m_valid = xfer && !pipeline_flush;
    if (xfer) m_data = (m_tripped && trip_enable) ? 0 : d;
    if (!trip_enable) begin
      m_tripped = 0; m_run = 0;
    end else if (m_tripped && trip_clear) begin
      m_tripped = 0; m_run = 0;
    end else if (pipeline_flush) begin
      if (!m_tripped) m_run = 0;
    end else if (xfer && !m_tripped) begin
      if (hi || lo) begin
        m_run++;
        if (m_run >= int'(debounce_len)) begin
          m_tripped = 1; m_run = 0; m_fh = hi;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table (thresholds +-1000, debounce 3, ready high unless
  // stated)
  // --------------------------------------------------------------------------
  typedef struct {
    bit v; int d; bit fl; bit clr; bit en;
    bit e_v; int e_d; bit e_f; bit e_fh;
  } vec_t;

  vec_t tbl[24];

  initial begin
    //            v  d      fl clr en   e_v e_d    e_f e_fh
    tbl[0]  = '{1,  1200, 0, 0, 1,  1,  1200, 0, 0};
    tbl[1]  = '{1,  1200, 0, 0, 1,  1,  1200, 0, 0};
    tbl[2]  = '{1,   500, 0, 0, 1,  1,   500, 0, 0};
    tbl[3]  = '{1,  1200, 0, 0, 1,  1,  1200, 0, 0};
    tbl[4]  = '{1,  1200, 0, 0, 1,  1,  1200, 0, 0};
    tbl[5]  = '{1,     0, 0, 0, 1,  1,     0, 0, 0};
    tbl[6]  = '{1,  1200, 0, 0, 1,  1,  1200, 0, 0};
    tbl[7]  = '{1,  1300, 0, 0, 1,  1,  1300, 0, 0};
    tbl[8]  = '{1,  1400, 0, 0, 1,  1,  1400, 1, 1};
    tbl[9]  = '{1,  1500, 0, 0, 1,  1,     0, 1, 1};
    tbl[10] = '{0,     0, 0, 0, 1,  0,     0, 1, 1};
    tbl[11] = '{1, -2000, 0, 1, 1,  1,     0, 0, 1};
    tbl[12] = '{1, -2000, 0, 0, 1,  1, -2000, 0, 1};
    tbl[13] = '{1, -2000, 0, 0, 1,  1, -2000, 0, 1};
    tbl[14] = '{1, -2000, 0, 0, 1,  1, -2000, 1, 0};
    tbl[15] = '{1,     5, 0, 0, 1,  1,     0, 1, 0};
    tbl[16] = '{1,  3000, 0, 0, 0,  1,  3000, 0, 0};
    tbl[17] = '{1,  3000, 0, 0, 1,  1,  3000, 0, 0};
    tbl[18] = '{1,  3000, 1, 0, 1,  0,  3000, 0, 0};
    tbl[19] = '{1,  3000, 0, 0, 1,  1,  3000, 0, 0};
    tbl[20] = '{1,  3000, 0, 0, 1,  1,  3000, 0, 0};
    tbl[21] = '{1,  3000, 0, 0, 1,  1,  3000, 1, 1};
    tbl[22] = '{0,     0, 1, 0, 1,  0,  3000, 1, 1};
    tbl[23] = '{0,     0, 0, 1, 1,  0,  3000, 0, 1};
  end

  initial begin
    reset        = 1'b0;
    thr_high     = 16'sd1000;
    thr_low      = -16'sd1000;
    debounce_len = 8'd3;
    drive(0, 1, 0, 0, 0, 1);

    repeat (3) tick();
    expect_out("reset", 0, 0, 0, 0);
    reset = 1'b1;
    tick();

    // ---------------- table -------------------------------------------------
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].v, 1, tbl[i].d, tbl[i].fl, tbl[i].clr, tbl[i].en);
      tick();
      expect_out($sformatf("row%0d", i), tbl[i].e_v, tbl[i].e_d,
                 tbl[i].e_f, tbl[i].e_fh);
    end

    // ---------------- ready stall keeps the count ---------------------------
    drive(1, 1, 1200, 0, 0, 1); tick();
    drive(1, 1, 1200, 0, 0, 1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1200, 0, 0, 1);
      #1 chk($sformatf("stall%0d.in_ready", i), data_in_ready, 0);
      tick();
      chk($sformatf("stall%0d.valid", i), data_out_valid, 0);
      chk($sformatf("stall%0d.fault", i), fault, 0);
    end
    drive(1, 1, 1200, 0, 0, 1);
    #1 chk("resume.in_ready", data_in_ready, 1);
    tick();
    expect_out("stall_resume", 1, 1200, 1, 1);

    // ---------------- reset while PENDING (count 2) -------------------------
    drive(0, 1, 0, 0, 1, 1); tick();
    chk("clear.fault", fault, 0);
    drive(1, 1, 1200, 0, 0, 1); tick();
    drive(1, 1, 1200, 0, 0, 1); tick();
    drive(0, 1, 0, 0, 0, 1);
    #2 reset = 1'b0;
    #1 expect_out("rst_pend", 0, 0, 0, 0);
    tick(); tick();
    #1 reset = 1'b1;
    drive(1, 1, 1200, 0, 0, 1); tick();
    expect_out("post_rst1", 1, 1200, 0, 0);
    tick();
    chk("post_rst2.fault", fault, 0);
    tick();
    expect_out("post_rst3", 1, 1200, 1, 1);

    // ---------------- reset while TRIPPED ------------------------------------
    drive(0, 1, 0, 0, 0, 1);
    #2 reset = 1'b0;
    #1 expect_out("rst_trip", 0, 0, 0, 0);
    tick();
    #1 reset = 1'b1;
    drive(1, 1, 1200, 0, 0, 1); tick();
    expect_out("post_rst_trip", 1, 1200, 0, 0);
    drive(1, 1, 0, 0, 0, 1); tick();

    // ---------------- inverted window, debounce 1 ---------------------------
    thr_high = -16'sd10; thr_low = 16'sd10; debounce_len = 8'd1;
    drive(1, 1, 0, 0, 0, 1); tick();
    expect_out("inv_window", 1, 0, 1, 1);
    drive(0, 1, 0, 0, 1, 1); tick();
    chk("inv_clear.fault", fault, 0);

    // ---------------- debounce_len lowered below count ----------------------
    thr_high = 16'sd1000; thr_low = -16'sd1000; debounce_len = 8'd5;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, -1500, 0, 0, 1); tick();
    end
    chk("len5.fault", fault, 0);
    debounce_len = 8'd2;
    drive(1, 1, -1500, 0, 0, 1); tick();
    expect_out("len_lowered", 1, -1500, 1, 0);

    // ---------------- randomized run against the model ----------------------
    drive(0, 1, 0, 0, 0, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        thr_high = 16'(int'($urandom_range(800, 0)) - 200);
        thr_low  = 16'(int'($urandom_range(800, 0)) - 600);
      end
      if (c % 37 == 0) debounce_len = 8'($urandom_range(5, 0));
      drive($urandom_range(99, 0) < 70,
            $urandom_range(99, 0) < 80,
            int'($urandom_range(3000, 0)) - 1500,
            $urandom_range(99, 0) < 5,
            $urandom_range(99, 0) < 8,
            $urandom_range(99, 0) < 96);
      #1 chk("rnd.in_ready", data_in_ready, data_out_ready);
      model_edge();
      tick();
      chk($sformatf("rnd%0d.valid", c), data_out_valid, m_valid);
      chk($sformatf("rnd%0d.data", c),  data_out_data,  m_data);
      chk($sformatf("rnd%0d.fault", c), fault,          m_tripped);
      chk($sformatf("rnd%0d.fh", c),    fault_high,     m_fh);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_adc_range_guard
`default_nettype wire
